alu_issue_stage: RTL

Pipeline register that sits directly upstream of the ALU, between decode/register-read and execute. Accepts decoded operations over a valid/ready handshake and holds up to two in a skid buffer. Resolves the immediate-vs-register second operand and presents `ALUc`, `data1` and `data2` to the ALU. Discards queued work on a taken-branch flush and can optionally forward a late write-back result into held operands.

---
 rtl/alu_issue_pkg.sv | 47 ++++
 rtl/alu_issue_stage_fwd_mux.sv | 30 +++
 rtl/alu_issue_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU control encodings, the
// buffered-entry layout and a few structural constants.
package alu_issue_pkg;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Same 4-bit ALUc encoding the decoder produces and the ALU consumes.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_BEQ  = 4'b1000,
        ALU_BNE  = 4'b1001,
        ALU_BLT  = 4'b1010,
        ALU_BGE  = 4'b1011,
        ALU_BLTU = 4'b1100,
        ALU_BGEU = 4'b1101,
        ALU_JAL  = 4'b1110,
        ALU_JALR = 4'b1111
    } aluc_e;

    typedef struct packed {
        logic [3:0]        aluc;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [4:0]        rs_idx;
        logic [4:0]        rt_idx;
        logic [4:0]        rd_idx;
        logic              use_imm;
    } entry_t;

    function automatic logic [DATA_W-1:0] resolve_op2(
        input logic              use_imm,
        input logic [DATA_W-1:0] rt_data,
        input logic [DATA_W-1:0] imm
    );
        return use_imm ? imm : rt_data;
    endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Compare-and-replace of one entry's operands against a late write-back.
// Only built when ALU_ISSUE_FWD_EN is defined.
`ifdef ALU_ISSUE_FWD_EN
module issue_fwd_mux
    import alu_issue_pkg::*;
(
    input  entry_t              entry_i,
    input  logic                fwd_valid_i,
    input  logic [4:0]          fwd_rd_i,
    input  logic [DATA_W-1:0]   fwd_data_i,
    output entry_t              entry_o
);

    logic fwd_live;

    // Register 0 is hard-wired, so a write-back to it must never leak into an operand.
    assign fwd_live = fwd_valid_i && (fwd_rd_i != REG_ZERO);

    always_comb begin
        entry_o = entry_i;
        if (fwd_live && (entry_i.rs_idx == fwd_rd_i)) begin
            entry_o.data1 = fwd_data_i;
        end
        if (fwd_live && !entry_i.use_imm && (entry_i.rt_idx == fwd_rd_i)) begin
            entry_o.data2 = fwd_data_i;
        end
    end

endmodule
`endif

// File: rtl/alu_issue_stage.sv
// Two-entry skid buffer in front of the ALU: resolves operand 2, drops work on
// flush, and forwards late write-backs into held operands when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_aluc,
    input  logic [DW-1:0] in_rs_data,
    input  logic [DW-1:0] in_rt_data,
    input  logic [DW-1:0] in_imm,
    input  logic          in_use_imm,
    input  logic [4:0]    in_rs_idx,
    input  logic [4:0]    in_rt_idx,
    input  logic [4:0]    in_rd_idx,
    input  logic          flush,
    input  logic          fwd_valid,
    input  logic [4:0]    fwd_rd,
    input  logic [DW-1:0] fwd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [3:0]    out_aluc,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic [4:0]    out_rd,
    output logic [1:0]    occupancy
);

    entry_t        mem_q [2];
    entry_t        mem_d [2];
    entry_t        held  [2];
    entry_t        in_ent;
    entry_t        in_res;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [3:0]    out_aluc_q, out_aluc_d;
    logic [DW-1:0] out_data1_q, out_data1_d;
    logic [DW-1:0] out_data2_q, out_data2_d;
    logic [4:0]    out_rd_q, out_rd_d;
    logic          enq;
    logic          deq;

    assign in_ready  = rst_n && !flush && (count_q != 2'(DEPTH));
    assign out_valid = (count_q != 2'd0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;

    always_comb begin
        in_ent         = '0;
        in_ent.aluc    = in_aluc;
        in_ent.data1   = in_rs_data;
        in_ent.data2   = resolve_op2(in_use_imm, in_rt_data, in_imm);
        in_ent.rs_idx  = in_rs_idx;
        in_ent.rt_idx  = in_rt_idx;
        in_ent.rd_idx  = in_rd_idx;
        in_ent.use_imm = in_use_imm;
    end

`ifdef ALU_ISSUE_FWD_EN
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        issue_fwd_mux u_fwd (
            .entry_i     (mem_q[gi]),
            .fwd_valid_i (fwd_valid),
            .fwd_rd_i    (fwd_rd),
            .fwd_data_i  (fwd_data),
            .entry_o     (held[gi])
        );
    end

    issue_fwd_mux u_fwd_in (
        .entry_i     (in_ent),
        .fwd_valid_i (fwd_valid),
        .fwd_rd_i    (fwd_rd),
        .fwd_data_i  (fwd_data),
        .entry_o     (in_res)
    );
`else
    for (genvar gi = 0; gi < 2; gi++) begin : g_hold
        assign held[gi] = mem_q[gi];
    end

    assign in_res = in_ent;

    // Write-back ports stay on the boundary but carry no function in this build.
    logic [DW+5:0] unused_fwd;
    assign unused_fwd = {fwd_valid, fwd_rd, fwd_data};
`endif

    always_comb begin
        mem_d    = held;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = in_res;
                wr_ptr_d        = !wr_ptr_q;
            end
            if (deq) begin
                rd_ptr_d = !rd_ptr_q;
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Head is re-registered so an emptied buffer keeps showing the last head.
    always_comb begin
        out_aluc_d  = out_aluc_q;
        out_data1_d = out_data1_q;
        out_data2_d = out_data2_q;
        out_rd_d    = out_rd_q;
        if (count_d != 2'd0) begin
            out_aluc_d  = mem_d[rd_ptr_d].aluc;
            out_data1_d = mem_d[rd_ptr_d].data1;
            out_data2_d = mem_d[rd_ptr_d].data2;
            out_rd_d    = mem_d[rd_ptr_d].rd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            out_aluc_q  <= '0;
            out_data1_q <= '0;
            out_data2_q <= '0;
            out_rd_q    <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_aluc_q  <= out_aluc_d;
            out_data1_q <= out_data1_d;
            out_data2_q <= out_data2_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign out_aluc  = out_aluc_q;
    assign out_data1 = out_data1_q;
    assign out_data2 = out_data2_q;
    assign out_rd    = out_rd_q;
    assign occupancy = count_q;

endmodule
